serial_frame_rx: RTL and testbench

- Downstream consumer of the single-bit flip-flop stage (clk, d, P, C -> Q).
- Treats that registered Q as a serial line and samples one bit per enabled clock.
- Frames each word as: start bit (0), WIDTH data bits LSB-first, optional even-parity bit, stop bit (1).
- Presents each received word on a valid/ready output with parity, framing and overrun status.

---
 rtl/serial_frame_rx_pkg.sv | 23 ++
 rtl/serial_frame_rx_shift_reg.sv | 28 ++
 rtl/serial_frame_rx.sv | 107 ++++++++++
 tb/tb_serial_frame_rx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_rx_pkg.sv
// Shared definitions for the serial frame receiver: FSM state encoding and
// the bit-counter width helper.
package serial_frame_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DATA    = 3'd1,
        ST_PARITY  = 3'd2,
        ST_STOP    = 3'd3,
        ST_WAIT_HI = 3'd4
    } state_t;

    // Bits needed to index n positions; never less than one.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_frame_rx_shift_reg.sv
// Receive shift register: writes one indexed bit per enabled edge and
// exposes the XOR of all stored bits for the parity comparison.
module rx_shift_reg
    import serial_frame_rx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             C_n,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] idx,
    input  logic             bit_in,
    output logic [WIDTH-1:0] shift,
    output logic             parity
);

    always_ff @(posedge clk or negedge C_n) begin
        if (!C_n) begin
            shift <= '0;
        end else if (wr_en) begin
            shift[idx] <= bit_in;
        end
    end

    assign parity = ^shift;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits LSB-first, optional even
// parity, stop bit; delivers words on a valid/ready port with error status.
module serial_frame_rx
    import serial_frame_rx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             C_n,
    input  logic             bit_in,
    input  logic             bit_en,
    input  logic             ready_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             par_err,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    localparam int               CNT_W = clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             pend_perr;
    logic [WIDTH-1:0] shift;
    logic             parity;
    logic             shift_wr;

    assign shift_wr = bit_en && (state == ST_DATA);
    assign busy     = (state != ST_IDLE);

    rx_shift_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_shift (
        .clk    (clk),
        .C_n    (C_n),
        .wr_en  (shift_wr),
        .idx    (cnt),
        .bit_in (bit_in),
        .shift  (shift),
        .parity (parity)
    );

    always_ff @(posedge clk or negedge C_n) begin
        if (!C_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            pend_perr <= 1'b0;
            data_out  <= '0;
            valid_out <= 1'b0;
            par_err   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            // Handshake and error clear run every edge; a same-edge overrun
            // set further down takes precedence over err_clr.
            if (valid_out && ready_in) valid_out <= 1'b0;
            if (err_clr) overrun <= 1'b0;

            if (bit_en) begin
                case (state)
                    ST_IDLE: begin
                        cnt <= '0;
                        if (!bit_in) state <= ST_DATA;
                    end
                    ST_DATA: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            if (PARITY_EN) state <= ST_PARITY;
                            else           state <= ST_STOP;
                        end
                    end
                    ST_PARITY: begin
                        pend_perr <= parity ^ bit_in;
                        state     <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (bit_in) begin
                            state <= ST_IDLE;
                            if (!valid_out || ready_in) begin
                                data_out  <= shift;
                                par_err   <= pend_perr & PARITY_EN;
                                valid_out <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_WAIT_HI;
                        end
                    end
                    ST_WAIT_HI: begin
                        if (bit_in) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx (WIDTH=8, PARITY_EN=1) driven by
// directed frames with hand-computed parity bits and expected words.
module tb_serial_frame_rx;

    logic       clk = 1'b0;
    logic       C_n;
    logic       bit_in;
    logic       bit_en;
    logic       ready_in;
    logic       err_clr;
    logic [7:0] data_out;
    logic       valid_out;
    logic       par_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int         checks = 0;
    int         errors = 0;
    int         busy_cnt;
    logic [8:0] sb[$];
    logic [8:0] mon_exp;

    serial_frame_rx #(
        .WIDTH     (8),
        .PARITY_EN (1'b1)
    ) dut (
        .clk       (clk),
        .C_n       (C_n),
        .bit_in    (bit_in),
        .bit_en    (bit_en),
        .ready_in  (ready_in),
        .err_clr   (err_clr),
        .data_out  (data_out),
        .valid_out (valid_out),
        .par_err   (par_err),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One enabled sample, then `gap` disabled cycles with the line inverted.
    task automatic send_bit(input logic b, input int gap);
        bit_in = b;
        bit_en = 1'b1;
        @(posedge clk);
        #1;
        bit_en = 1'b0;
        if (busy) busy_cnt++;
        for (int i = 0; i < gap; i++) begin
            bit_in = ~b;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop,
                              input int gap, input logic rdy_stop, input logic push,
                              input logic exp_perr);
        busy_cnt = 0;
        send_bit(1'b0, gap);
        for (int i = 0; i < 8; i++) send_bit(d[i], gap);
        send_bit(pbit, gap);
        if (push) sb.push_back({exp_perr, d});
        ready_in = rdy_stop;
        send_bit(stop, gap);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted word is matched against the scoreboard queue.
    always @(negedge clk) begin
        if (C_n && valid_out && ready_in) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %0h expected none", data_out);
            end else begin
                mon_exp = sb.pop_front();
                check("mon_data", 16'(data_out), 16'(mon_exp[7:0]));
                check("mon_perr", 16'(par_err), 16'(mon_exp[8]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        C_n = 1'b1; bit_in = 1'b1; bit_en = 1'b0; ready_in = 1'b0; err_clr = 1'b0;
        #2 C_n = 1'b0;
        #1;
        check("rst_valid", 16'(valid_out), 16'd0);
        check("rst_data", 16'(data_out), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_overrun", 16'(overrun), 16'd0);
        check("rst_frame_err", 16'(frame_err), 16'd0);
        tick(); tick();
        C_n = 1'b1;
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        check("idle_high_busy", 16'(busy), 16'd0);

        // Good frame 0xA5, parity bit 0
        send_frame(8'hA5, 1'b0, 1'b1, 0, 1'b1, 1'b1, 1'b0);
        check("a5_valid", 16'(valid_out), 16'd1);
        check("a5_data", 16'(data_out), 16'h00A5);
        check("a5_busy_cycles", 16'(busy_cnt), 16'd10);
        check("a5_busy_after", 16'(busy), 16'd0);
        tick();
        check("a5_valid_drop", 16'(valid_out), 16'd0);

        // Parity error: 0xA5 with parity bit 1
        send_frame(8'hA5, 1'b1, 1'b1, 0, 1'b1, 1'b1, 1'b1);
        check("perr_valid", 16'(valid_out), 16'd1);
        check("perr_flag", 16'(par_err), 16'd1);
        tick();

        // Framing error on 0x3C, line held low 5 samples, then high
        send_frame(8'h3C, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        check("ferr_pulse", 16'(frame_err), 16'd1);
        check("ferr_valid", 16'(valid_out), 16'd0);
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b0, 0);
            check("ferr_hold_busy", 16'(busy), 16'd1);
        end
        check("ferr_one_cycle", 16'(frame_err), 16'd0);
        send_bit(1'b1, 0);
        check("ferr_line_high", 16'(busy), 16'd0);
        send_bit(1'b1, 0);
        check("ferr_idle", 16'(busy), 16'd0);

        // Overrun: 0x11 pending, 0x22 dropped
        send_frame(8'h11, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0);
        check("ovr_first_valid", 16'(valid_out), 16'd1);
        check("ovr_first_flag", 16'(overrun), 16'd0);
        send_frame(8'h22, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        check("ovr_data_kept", 16'(data_out), 16'h0011);
        check("ovr_set", 16'(overrun), 16'd1);
        check("ovr_valid_held", 16'(valid_out), 16'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ovr_cleared", 16'(overrun), 16'd0);
        check("ovr_valid_still", 16'(valid_out), 16'd1);
        ready_in = 1'b1;
        tick();
        check("ovr_accept_drop", 16'(valid_out), 16'd0);
        check("ovr_data_hold", 16'(data_out), 16'h0011);

        // bit_en every 3rd cycle for 0x5A, then back-to-back 0x07 (parity 1)
        send_frame(8'h5A, 1'b0, 1'b1, 2, 1'b0, 1'b1, 1'b0);
        check("gate_data", 16'(data_out), 16'h005A);
        check("gate_valid", 16'(valid_out), 16'd1);
        send_frame(8'h07, 1'b1, 1'b1, 0, 1'b1, 1'b1, 1'b0);
        check("b2b_valid", 16'(valid_out), 16'd1);
        check("b2b_data", 16'(data_out), 16'h0007);
        check("b2b_overrun", 16'(overrun), 16'd0);
        tick();
        check("b2b_drop", 16'(valid_out), 16'd0);

        // Reset mid-frame with a pending word (par_err=1) and overrun set
        send_frame(8'hC3, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b1);
        send_frame(8'h44, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        check("pre_rst_overrun", 16'(overrun), 16'd1);
        check("pre_rst_perr", 16'(par_err), 16'd1);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        bit_en = 1'b1;
        bit_in = 1'b0;
        #2 C_n = 1'b0;
        #1;
        sb.delete();
        check("mid_rst_valid", 16'(valid_out), 16'd0);
        check("mid_rst_data", 16'(data_out), 16'd0);
        check("mid_rst_perr", 16'(par_err), 16'd0);
        check("mid_rst_overrun", 16'(overrun), 16'd0);
        check("mid_rst_busy", 16'(busy), 16'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            bit_in = ~bit_in;
        end
        check("rst_hold_busy", 16'(busy), 16'd0);
        check("rst_hold_ferr", 16'(frame_err), 16'd0);
        C_n = 1'b1;
        bit_en = 1'b0;
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        check("post_rst_busy", 16'(busy), 16'd0);
        check("post_rst_valid", 16'(valid_out), 16'd0);
        send_frame(8'h96, 1'b0, 1'b1, 0, 1'b1, 1'b1, 1'b0);
        check("post_rst_data", 16'(data_out), 16'h0096);
        tick();
        tick();
        check("sb_empty", 16'(sb.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
